// File: rtl/ama_riscv_spec_tracker.sv
// Speculation tracker: in-order queue of predicted branches in flight.
// Resolves them at execute and flags mispredicts with the redirect PC.
module ama_riscv_spec_tracker #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dec_br_valid,
    input  logic [PC_W-1:0]            dec_pc,
    input  logic                       dec_pred,
    input  logic [PC_W-1:0]            dec_pc_alt,
    input  logic                       exe_br_valid,
    input  logic                       exe_br_taken,
    input  logic                       flush_ext,
    output logic                       spec_enter,
    output logic                       spec_resolve,
    output logic                       br_res,
    output logic [PC_W-1:0]            pc_dec,
    output logic [PC_W-1:0]            pc_exe,
    output logic                       mispredict,
    output logic [PC_W-1:0]            redirect_pc,
    output logic                       stall_dec,
    output logic [$clog2(DEPTH+1)-1:0] inflight,
    output logic                       proto_err,
    output logic [CNT_W-1:0]           pred_cnt,
    output logic [CNT_W-1:0]           mispred_cnt
);
    // DEPTH=1 would give a zero-width pointer; keep at least one bit
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
        logic [PC_W-1:0] pc_alt;
    } entry_t;

    entry_t           q [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    entry_t           head;
    logic             kill;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head         = q[rd_ptr];
    assign stall_dec    = (inflight == OCC_W'(DEPTH));
    assign spec_resolve = exe_br_valid && (inflight != '0) && !flush_ext;
    assign br_res       = exe_br_taken;
    assign pc_dec       = dec_pc;
    assign pc_exe       = head.pc;
    assign redirect_pc  = head.pc_alt;
    assign mispredict   = spec_resolve && (head.pred != exe_br_taken);
    // decode branch is wrong-path whenever the pipe is being redirected
    assign spec_enter   = dec_br_valid && !stall_dec && !mispredict && !flush_ext;
    assign kill         = flush_ext || mispredict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (kill) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= '0;
        end else begin
            if (spec_enter) begin
                q[wr_ptr] <= '{pc: dec_pc, pred: dec_pred, pc_alt: dec_pc_alt};
                wr_ptr    <= ptr_inc(wr_ptr);
            end
            if (spec_resolve) rd_ptr <= ptr_inc(rd_ptr);
            if (spec_enter && !spec_resolve)      inflight <= inflight + OCC_W'(1);
            else if (!spec_enter && spec_resolve) inflight <= inflight - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err   <= 1'b0;
            pred_cnt    <= '0;
            mispred_cnt <= '0;
        end else begin
            if (exe_br_valid && inflight == '0) proto_err <= 1'b1;
            if (spec_resolve && pred_cnt != '1) pred_cnt <= pred_cnt + CNT_W'(1);
            if (mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ama_riscv_spec_tracker.sv
// Directed bench for ama_riscv_spec_tracker; a CNT_W=2 copy shares stimulus
// to exercise counter saturation.
module tb_ama_riscv_spec_tracker;
    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            dec_br_valid, dec_pred, exe_br_valid, exe_br_taken, flush_ext;
    logic [PC_W-1:0] dec_pc, dec_pc_alt;

    logic            spec_enter, spec_resolve, br_res, mispredict, stall_dec, proto_err;
    logic [PC_W-1:0] pc_dec, pc_exe, redirect_pc;
    logic [1:0]      inflight;
    logic [15:0]     pred_cnt, mispred_cnt;

    logic            s_enter, s_resolve, s_br_res, s_mispredict, s_stall, s_proto_err;
    logic [PC_W-1:0] s_pc_dec, s_pc_exe, s_redirect;
    logic [1:0]      s_inflight;
    logic [1:0]      s_pred_cnt, s_mispred_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ama_riscv_spec_tracker #(.DEPTH(2), .PC_W(PC_W), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .dec_br_valid(dec_br_valid), .dec_pc(dec_pc), .dec_pred(dec_pred), .dec_pc_alt(dec_pc_alt),
        .exe_br_valid(exe_br_valid), .exe_br_taken(exe_br_taken), .flush_ext(flush_ext),
        .spec_enter(spec_enter), .spec_resolve(spec_resolve), .br_res(br_res),
        .pc_dec(pc_dec), .pc_exe(pc_exe), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stall_dec(stall_dec), .inflight(inflight), .proto_err(proto_err),
        .pred_cnt(pred_cnt), .mispred_cnt(mispred_cnt)
    );

    ama_riscv_spec_tracker #(.DEPTH(2), .PC_W(PC_W), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .dec_br_valid(dec_br_valid), .dec_pc(dec_pc), .dec_pred(dec_pred), .dec_pc_alt(dec_pc_alt),
        .exe_br_valid(exe_br_valid), .exe_br_taken(exe_br_taken), .flush_ext(flush_ext),
        .spec_enter(s_enter), .spec_resolve(s_resolve), .br_res(s_br_res),
        .pc_dec(s_pc_dec), .pc_exe(s_pc_exe), .mispredict(s_mispredict), .redirect_pc(s_redirect),
        .stall_dec(s_stall), .inflight(s_inflight), .proto_err(s_proto_err),
        .pred_cnt(s_pred_cnt), .mispred_cnt(s_mispred_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // next negedge, then apply inputs; comb outputs settle #1 later
    task automatic drv(input logic dv, input logic [31:0] pc, input logic pr, input logic [31:0] alt,
                       input logic ev, input logic et, input logic fl);
        @(negedge clk);
        dec_br_valid = dv; dec_pc = pc; dec_pred = pr; dec_pc_alt = alt;
        exe_br_valid = ev; exe_br_taken = et; flush_ext = fl;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        dec_br_valid = 0; dec_pc = '0; dec_pred = 0; dec_pc_alt = '0;
        exe_br_valid = 0; exe_br_taken = 0; flush_ext = 0;
        #12;
        chk("rst_inflight", inflight, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_pred_cnt", pred_cnt, 0);
        chk("rst_stall", stall_dec, 0);
        rst_n = 1'b1;

        // single predict-taken branch, resolves taken the next cycle
        drv(1, 32'h100, 1, 32'h104, 0, 0, 0);
        chk("t1_enter", spec_enter, 1);
        chk("t1_pc_dec", pc_dec, 32'h100);
        drv(0, 0, 0, 0, 1, 1, 0);
        chk("t1_resolve", spec_resolve, 1);
        chk("t1_br_res", br_res, 1);
        chk("t1_pc_exe", pc_exe, 32'h100);
        chk("t1_mispred", mispredict, 0);
        idle();
        chk("t1_pred_cnt", pred_cnt, 1);
        chk("t1_inflight", inflight, 0);

        // fill to DEPTH, decode stalls
        drv(1, 32'h200, 1, 32'h210, 0, 0, 0);
        drv(1, 32'h204, 0, 32'h280, 0, 0, 0);
        chk("t2_enter2", spec_enter, 1);
        drv(1, 32'h208, 1, 32'h20c, 0, 0, 0);
        chk("t2_stall", stall_dec, 1);
        chk("t2_enter_blk", spec_enter, 0);
        chk("t2_inflight", inflight, 2);
        drv(1, 32'h208, 1, 32'h20c, 1, 1, 0);
        chk("t2_no_bypass", spec_enter, 0);
        chk("t2_resolve", spec_resolve, 1);
        chk("t2_pc_exe", pc_exe, 32'h200);
        drv(0, 0, 0, 0, 1, 0, 0);
        chk("t2_stall_drop", stall_dec, 0);
        chk("t2_inflight1", inflight, 1);
        chk("t2_pc_exe2", pc_exe, 32'h204);
        chk("t2_nt_ok", mispredict, 0);
        idle();
        chk("t2_pred_cnt", pred_cnt, 3);
        chk("t2_inflight0", inflight, 0);

        // mispredict on head kills the younger entry and the decode branch
        drv(1, 32'h300, 0, 32'h340, 0, 0, 0);
        drv(1, 32'h308, 1, 32'h30c, 0, 0, 0);
        drv(1, 32'h310, 1, 32'h314, 1, 1, 0);
        chk("t3_mispred", mispredict, 1);
        chk("t3_redirect", redirect_pc, 32'h340);
        chk("t3_enter_kill", spec_enter, 0);
        idle();
        chk("t3_inflight", inflight, 0);
        chk("t3_mispred_cnt", mispred_cnt, 1);
        chk("t3_pred_cnt", pred_cnt, 4);
        chk("sat_pred_cnt", s_pred_cnt, 3);
        chk("sat_mispred_cnt", s_mispred_cnt, 1);

        // resolve against an empty queue
        drv(0, 0, 0, 0, 1, 0, 0);
        chk("t4_no_resolve", spec_resolve, 0);
        chk("t4_no_mispred", mispredict, 0);
        idle();
        chk("t4_proto", proto_err, 1);
        chk("t4_cnt_hold", pred_cnt, 4);
        idle();
        chk("t4_proto_sticky", proto_err, 1);

        // external flush overrides a simultaneous enter and resolve
        drv(1, 32'h400, 1, 32'h404, 0, 0, 0);
        drv(1, 32'h404, 1, 32'h408, 0, 0, 0);
        drv(1, 32'h408, 1, 32'h40c, 1, 0, 1);
        chk("t5_enter", spec_enter, 0);
        chk("t5_resolve", spec_resolve, 0);
        chk("t5_mispred", mispredict, 0);
        idle();
        chk("t5_inflight", inflight, 0);
        chk("t5_pred_cnt", pred_cnt, 4);
        chk("t5_mispred_cnt", mispred_cnt, 1);

        // fifth resolve: wide counter advances, narrow one stays saturated
        drv(1, 32'h500, 1, 32'h504, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 1, 0);
        drv(1, 32'h600, 1, 32'h604, 0, 0, 0);
        chk("t6_pred_cnt", pred_cnt, 5);
        chk("t6_sat_hold", s_pred_cnt, 3);

        // async reset mid-cycle with an entry in flight and a would-be mispredict
        drv(0, 0, 0, 0, 1, 0, 0);
        chk("t7_pre_mispred", mispredict, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t7_inflight", inflight, 0);
        chk("t7_mispred", mispredict, 0);
        chk("t7_pred_cnt", pred_cnt, 0);
        chk("t7_mispred_cnt", mispred_cnt, 0);
        chk("t7_proto", proto_err, 0);
        chk("t7_sat_cnt", s_pred_cnt, 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ama_riscv_spec_tracker.md
Name: ama_riscv_spec_tracker

Overview:
- Drives the branch predictor's pipeline interface: produces speculation enter/resolve events, the actual branch result, and decode/execute PCs.
- Keeps a small in-order queue of in-flight predicted branches, with prediction and alternate-path PC per branch.
- At execute, compares each prediction with the actual outcome and raises mispredict with the redirect PC.
- Maintains saturating prediction and mispredict counters.

Parameters:
DEPTH, 2, max in-flight predicted branches (power of 2, >=1)
PC_W, 32, PC width
CNT_W, 16, perf counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset
dec_br_valid  in  1  branch in decode with prediction available
dec_pc  in  PC_W  decode branch PC
dec_pred  in  1  prediction (1 = taken)
dec_pc_alt  in  PC_W  not-predicted path PC (fallthrough if pred T, target if pred NT)
exe_br_valid  in  1  branch resolving in execute
exe_br_taken  in  1  actual outcome
flush_ext  in  1  external flush (trap/exception); kills all in-flight
spec_enter  out  1  prediction committed to tracker
spec_resolve  out  1  head branch resolved
br_res  out  1  actual outcome to predictor (valid with spec_resolve)
pc_dec  out  PC_W  = dec_pc passthrough
pc_exe  out  PC_W  head entry PC
mispredict  out  1  head prediction != outcome
redirect_pc  out  PC_W  head entry alt PC
stall_dec  out  1  queue full, decode must hold
inflight  out  $clog2(DEPTH+1)  occupancy
proto_err  out  1  sticky: resolve with empty queue
pred_cnt  out  CNT_W  resolved branches, saturating
mispred_cnt  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset: one clock, asynchronous, active-low reset named rst_n. Asserting rst_n low asynchronously clears the queue, inflight, proto_err and both counters to 0. Mid-operation reset discards all entries and raises no mispredict.
- Queue: circular FIFO, entry = {pc, pred, pc_alt}. rd/wr pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy counter is tracked separately.
- stall_dec = (inflight == DEPTH), from registered state only. No same-cycle bypass of a simultaneous resolve.
- spec_resolve = exe_br_valid && inflight!=0 && !flush_ext (combinational).
- br_res = exe_br_taken.
- pc_exe / redirect_pc = head entry fields. They are don't-care when empty.
- mispredict = spec_resolve && (head.pred != exe_br_taken), combinational, same cycle as resolve.
- spec_enter = dec_br_valid && !stall_dec && !mispredict && !flush_ext, combinational. The decode branch is wrong-path on mispredict or flush.
- Edge update, priority order:
  1. flush_ext: queue emptied, pointers and inflight set to 0.
  2. mispredict: queue emptied (all younger entries are wrong-path).
  3. Otherwise: pop on spec_resolve, push on spec_enter. Both at once keeps inflight unchanged and advances both pointers.
- Empty with exe_br_valid: no resolve, proto_err set (sticky until reset). A same-cycle enter is still accepted.
- Counters: pred_cnt +1 on spec_resolve; mispred_cnt +1 on mispredict. Both saturate at all-ones and never wrap.
- pc_dec = dec_pc, no register.
- Latency: an entered branch is eligible to resolve from the next cycle. All outputs except counters/inflight/proto_err are combinational from inputs plus registered state.

Test Plan:
- Enter pc=0x100 pred=T alt=0x104; next cycle resolve taken=1 -> spec_enter=1 in cycle 0; cycle 1: spec_resolve=1, br_res=1, pc_exe=0x100, mispredict=0; pred_cnt=1, inflight=0.
- DEPTH=2: enter 0x200 and 0x204 on consecutive cycles, then dec_br_valid held -> stall_dec=1, spec_enter=0, inflight=2. Resolve head -> stall_dec drops next cycle.
- Two in flight (0x300 pred NT alt=0x340, 0x308); resolve head taken=1 -> mispredict=1, redirect_pc=0x340; inflight=0 next cycle; mispred_cnt=1. A same-cycle dec_br_valid gives spec_enter=0.
- Empty queue, exe_br_valid=1 -> spec_resolve=0, proto_err=1 and stays 1.
- flush_ext with 2 in flight plus simultaneous enter/resolve -> spec_enter=0, spec_resolve=0, inflight=0, counters unchanged.
- Force pred_cnt to all-ones via CNT_W=2 (4 resolves) -> stays 3. Then drop rst_n mid-cycle -> all outputs/counters 0 immediately.
